hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Hazard/forwarding controller for the 5-stage LC-3b pipeline. Keeps shadow copies of the
//  destination-register info for the EX, MEM and WB stages, and generates the per-operand
//  forwarding selects for the EX-stage operand muxes. Detects load-use hazards and inserts
//  exactly one bubble. Freezes the pipe while the MEM stage waits on memory, and counts stall cycles.
// PARAMETERS
//  REG_AW  3   register-index width (8 GPRs)
//  CNT_W   16  width of stall_cnt performance counter
// PORTS
//  clk          in   1       pipeline clock
//  reset        in   1       synchronous, active-high
//  id_valid     in   1       valid instruction in decode
//  id_sr1       in   REG_AW  decode source reg 1
//  id_sr2       in   REG_AW  decode source reg 2
//  id_sr1_used  in   1       sr1 is read by the instruction
//  id_sr2_used  in   1       sr2 is read by the instruction
//  id_dr        in   REG_AW  decode destination reg
//  id_dr_we     in   1       instruction writes id_dr
//  id_is_load   in   1       instruction is LDR/LDB/LDI (data valid only at WB)
//  mem_stall    in   1       MEM stage waiting on memory response
//  flush        in   1       taken branch/JMP redirect; held by source until pipe_advance=1
//  pipe_advance out  1       all pipeline registers load this cycle
//  stall_if_id  out  1       hold PC and IF/ID register
//  bubble_ex    out  1       load an invalid (NOP) entry into ID/EX
//  fwd_a        out  2       EX operand A select: 00 regfile, 01 MEM result, 10 WB data
//  fwd_b        out  2       EX operand B select, same encoding
//  ctl_state    out  2       FSM state: 00 RUN, 01 LU_STALL, 10 MEM_WAIT
//  stall_cnt    out  CNT_W   saturating count of cycles with stall_if_id=1
// BEHAVIOUR
//  Shadow entries EX/MEM/WB each hold {valid, dr, we, is_load}. EX also holds {sr1, sr2, used1, used2}.
//  Reset (sync):
//   - All shadow valids 0, FSM=RUN, stall_cnt=0.
//   - In the reset cycle: pipe_advance=0, stall_if_id=0, bubble_ex=0, fwd_a=fwd_b=00.
//  Control outputs are combinational from registered state plus current inputs.
//  Priority: reset > mem_stall > flush > load-use > normal.
//  Load-use hazard lu:
//   - id_valid & EX.valid & EX.is_load & EX.we & ((id_sr1_used & id_sr1==EX.dr) | (id_sr2_used & id_sr2==EX.dr)).
//  mem_stall=1:
//   - pipe_advance=0, stall_if_id=1, bubble_ex=0; no shadow entry changes.
//   - FSM->MEM_WAIT. Stays there while mem_stall=1, then returns to RUN on the first cycle with mem_stall=0.
//  Otherwise pipe_advance=1 and WB<=MEM, MEM<=EX. The EX load depends on the case:
//   - flush=1: EX<=invalid, bubble_ex=1, stall_if_id=0; lu is ignored.
//   - lu=1: EX<=invalid, bubble_ex=1, stall_if_id=1, FSM->LU_STALL.
//   - else: EX<=ID entry (valid=id_valid), bubble_ex=0, stall_if_id=0.
//  LU_STALL:
//   - Lasts exactly one cycle, then RUN. The load is then in MEM, and lu cannot re-fire for the same pair.
//  Forwarding is evaluated from the EX shadow entry. For each used source s:
//   - MEM.valid & MEM.we & !MEM.is_load & MEM.dr==s -> 01 (youngest wins).
//   - else WB.valid & WB.we & WB.dr==s -> 10.
//   - else 00.
//   - Unused source or invalid EX -> 00. The value 11 is never driven.
//   - R0..R7 all forward; there is no hardwired-zero register.
//  fwd_a/fwd_b stay stable during MEM_WAIT, because the shadows are frozen.
//  stall_cnt: +1 every cycle with stall_if_id=1; saturates at all-ones; never wraps.
//  Reset mid-stall: state returns to RUN and shadows are invalidated the next cycle; pending lu/flush is dropped.
// TESTING
//  T1 ADD R1<-R2,R3 then ADD R4<-R1,R1 -> 2nd in EX: fwd_a=01, fwd_b=01; no stall.
//  T2 ADD R1, NOP, AND R5<-R1,R2 -> AND in EX: fwd_a=10, fwd_b=00.
//  T3 LDR R1 then ADD R2<-R1,R0:
//     - 1 cycle with stall_if_id=1, bubble_ex=1, ctl_state=01.
//     - ADD then reaches EX with fwd_a=10.
//     - stall_cnt=1.
//  T4 mem_stall high 3 cycles with a dependent instruction in EX:
//     - pipe_advance=0 for 3 cycles, ctl_state=10, fwd selects unchanged.
//     - stall_cnt+=3; advance resumes on the 4th cycle.
//  T5 flush together with a load-use condition -> bubble_ex=1, stall_if_id=0, no LU_STALL.
//  T6 Force stall_cnt near all-ones (CNT_W=4), hold mem_stall -> counter sticks at 4'hF.
//     Then reset mid-stall -> all outputs take their reset values.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl_if
// Description : Bundle between the LC-3b pipeline datapath and the
//               hazard/forwarding controller.
//               master : pipeline side (drives decode info, mem_stall, flush)
//               slave  : controller side (drives advance/stall/bubble,
//                        forwarding selects, state and stall counter)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_forward_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    // decode-stage instruction info
    logic              id_valid;
    logic [REG_AW-1:0] id_sr1;
    logic [REG_AW-1:0] id_sr2;
    logic              id_sr1_used;
    logic              id_sr2_used;
    logic [REG_AW-1:0] id_dr;
    logic              id_dr_we;
    logic              id_is_load;
    // pipeline events
    logic              mem_stall;
    logic              flush;
    // controller outputs
    logic              pipe_advance;
    logic              stall_if_id;
    logic              bubble_ex;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        ctl_state;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               id_dr, id_dr_we, id_is_load, mem_stall, flush,
        input  pipe_advance, stall_if_id, bubble_ex, fwd_a, fwd_b,
               ctl_state, stall_cnt
    );

    modport slave (
        input  id_valid, id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               id_dr, id_dr_we, id_is_load, mem_stall, flush,
        output pipe_advance, stall_if_id, bubble_ex, fwd_a, fwd_b,
               ctl_state, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Hazard/forwarding controller for the 5-stage LC-3b pipeline.
//               Shadows destination info of EX/MEM/WB, generates EX operand
//               forwarding selects, inserts one bubble on load-use, freezes
//               the pipe during memory waits and counts stall cycles.
// Ports       : clk    - pipeline clock
//               reset  - synchronous, active-high
//               bus    - hazard_forward_ctrl_if.slave (decode info, events,
//                        control/forwarding outputs, state, stall counter)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  wire                   clk,
    input  wire                   reset,
    hazard_forward_ctrl_if.slave  bus
);

    localparam logic [1:0] S_RUN      = 2'b00;
    localparam logic [1:0] S_LU_STALL = 2'b01;
    localparam logic [1:0] S_MEM_WAIT = 2'b10;

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_MEM = 2'b01;
    localparam logic [1:0] c_FWD_WB  = 2'b10;

    // ------------------------------------------------------------------
    // Shadow pipeline entries
    // ------------------------------------------------------------------
    logic              r_ex_valid, r_ex_we, r_ex_ld, r_ex_u1, r_ex_u2;
    logic [REG_AW-1:0] r_ex_dr, r_ex_sr1, r_ex_sr2;
    logic              r_mem_valid, r_mem_we, r_mem_ld;
    logic [REG_AW-1:0] r_mem_dr;
    // WB load data is already final, so WB needs no is_load tag for forwarding.
    logic              r_wb_valid, r_wb_we;
    logic [REG_AW-1:0] r_wb_dr;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_lu;
    logic              w_pipe_advance;
    logic              w_stall_if_id;
    logic              w_bubble_ex;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // Load in EX whose result the decode instruction needs: data only
    // exists at WB, so one bubble is required before the consumer enters EX.
    assign w_lu = bus.id_valid & r_ex_valid & r_ex_ld & r_ex_we &
                  ((bus.id_sr1_used & (bus.id_sr1 == r_ex_dr)) |
                   (bus.id_sr2_used & (bus.id_sr2 == r_ex_dr)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. LU_STALL always exits after one cycle because
    // the bubble it inserted leaves EX invalid, so lu cannot re-fire.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = S_RUN;
        if (bus.mem_stall) begin
            w_state_nxt = S_MEM_WAIT;
        end else if (bus.flush) begin
            w_state_nxt = S_RUN;
        end else if (w_lu) begin
            w_state_nxt = S_LU_STALL;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_pipe_advance = 1'b0;
        w_stall_if_id  = 1'b0;
        w_bubble_ex    = 1'b0;
        if (reset) begin
            w_pipe_advance = 1'b0;
        end else if (bus.mem_stall) begin
            w_stall_if_id = 1'b1;
        end else begin
            w_pipe_advance = 1'b1;
            if (bus.flush) begin
                w_bubble_ex = 1'b1;
            end else if (w_lu) begin
                w_bubble_ex   = 1'b1;
                w_stall_if_id = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow entries: frozen unless the pipe advances
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_we     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_ex_u1     <= 1'b0;
            r_ex_u2     <= 1'b0;
            r_ex_dr     <= '0;
            r_ex_sr1    <= '0;
            r_ex_sr2    <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_ld    <= 1'b0;
            r_mem_dr    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_dr     <= '0;
        end else if (w_pipe_advance) begin
            r_wb_valid  <= r_mem_valid;
            r_wb_we     <= r_mem_we;
            r_wb_dr     <= r_mem_dr;
            r_mem_valid <= r_ex_valid;
            r_mem_we    <= r_ex_we;
            r_mem_ld    <= r_ex_ld;
            r_mem_dr    <= r_ex_dr;
            r_ex_valid  <= bus.id_valid & ~w_bubble_ex;
            r_ex_we     <= bus.id_dr_we;
            r_ex_ld     <= bus.id_is_load;
            r_ex_u1     <= bus.id_sr1_used;
            r_ex_u2     <= bus.id_sr2_used;
            r_ex_dr     <= bus.id_dr;
            r_ex_sr1    <= bus.id_sr1;
            r_ex_sr2    <= bus.id_sr2;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_if_id && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. A load in MEM has no data yet, so it is skipped and the
    // search falls through to WB; MEM checked first so the youngest wins.
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_fwd(input logic [REG_AW-1:0] src,
                                         input logic              used);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (used) begin
            if (r_mem_valid && r_mem_we && !r_mem_ld && (r_mem_dr == src)) begin
                sel = c_FWD_MEM;
            end else if (r_wb_valid && r_wb_we && (r_wb_dr == src)) begin
                sel = c_FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = c_FWD_RF;
        w_fwd_b = c_FWD_RF;
        if (!reset && r_ex_valid) begin
            w_fwd_a = f_fwd(r_ex_sr1, r_ex_u1);
            w_fwd_b = f_fwd(r_ex_sr2, r_ex_u2);
        end
    end

    assign bus.pipe_advance = w_pipe_advance;
    assign bus.stall_if_id  = w_stall_if_id;
    assign bus.bubble_ex    = w_bubble_ex;
    assign bus.fwd_a        = w_fwd_a;
    assign bus.fwd_b        = w_fwd_b;
    assign bus.ctl_state    = r_state;
    assign bus.stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Directed, table-driven bench for hazard_forward_ctrl
//               (CNT_W=4 so counter saturation is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int c_AW = 3;
    localparam int c_CW = 4;

    logic clk;
    logic reset;

    hazard_forward_ctrl_if #(.REG_AW(c_AW), .CNT_W(c_CW)) bus ();

    hazard_forward_ctrl #(.REG_AW(c_AW), .CNT_W(c_CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       valid;
        logic [2:0] sr1, sr2;
        logic       u1, u2;
        logic [2:0] dr;
        logic       we, ld, ms, fl, rst;
        logic       e_pa, e_st, e_b;
        logic [1:0] e_fa, e_fb, e_state;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                                input logic u1, input logic u2, input logic [2:0] d,
                                input logic we, input logic ld, input logic ms, input logic fl,
                                input logic pa, input logic st, input logic b,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [1:0] s, input logic [3:0] c);
        vec_t r;
        r.valid = v; r.sr1 = s1; r.sr2 = s2; r.u1 = u1; r.u2 = u2; r.dr = d;
        r.we = we; r.ld = ld; r.ms = ms; r.fl = fl; r.rst = 1'b0;
        r.e_pa = pa; r.e_st = st; r.e_b = b; r.e_fa = fa; r.e_fb = fb;
        r.e_state = s; r.e_cnt = c;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        reset           = v.rst;
        bus.id_valid    = v.valid;
        bus.id_sr1      = v.sr1;
        bus.id_sr2      = v.sr2;
        bus.id_sr1_used = v.u1;
        bus.id_sr2_used = v.u2;
        bus.id_dr       = v.dr;
        bus.id_dr_we    = v.we;
        bus.id_is_load  = v.ld;
        bus.mem_stall   = v.ms;
        bus.flush       = v.fl;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " pipe_advance"}, 32'(bus.pipe_advance), 32'(v.e_pa));
        chk({tag, " stall_if_id"},  32'(bus.stall_if_id),  32'(v.e_st));
        chk({tag, " bubble_ex"},    32'(bus.bubble_ex),    32'(v.e_b));
        chk({tag, " fwd_a"},        32'(bus.fwd_a),        32'(v.e_fa));
        chk({tag, " fwd_b"},        32'(bus.fwd_b),        32'(v.e_fb));
        chk({tag, " ctl_state"},    32'(bus.ctl_state),    32'(v.e_state));
        chk({tag, " stall_cnt"},    32'(bus.stall_cnt),    32'(v.e_cnt));
    endtask

    // Drive 1 ns after the rising edge, check 3 ns later (well before the next edge).
    task automatic step(input string tag, input vec_t v);
        @(posedge clk);
        #1 drive(v);
        #3 check_all(tag, v);
    endtask

    initial begin
        vec_t v;
        //             valid sr1 sr2 u1 u2 dr we ld ms fl | pa st b fa fb st cnt
        // T1: ADD R1<-R2,R3 ; ADD R4<-R1,R1 -> MEM forward on both operands
        tbl.push_back(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        // T2: ADD R1 ; NOP ; AND R5<-R1,R2 -> WB forward on A only
        tbl.push_back(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0));
        // T3: LDR R1 ; ADD R2<-R1,R0 -> one load-use bubble, then WB forward
        tbl.push_back(mk(1, 6, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 2, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        // T4: dependent ADD in EX, mem_stall for 3 cycles, then resume
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 2, 4));
        // T5: LDR R3 ; ADD R5<-R3,R3 with flush -> bubble, no stall, no LU_STALL
        tbl.push_back(mk(1, 4, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 3, 3, 1, 1, 5, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));

        // Reset: inputs idle, reset held across two edges
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst = 1'b1;
        drive(v);
        @(posedge clk);
        #4 check_all("reset", v);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("v%0d", i), tbl[i]);
        end

        // T6: hold mem_stall; counter climbs from 4 and sticks at 4'hF
        for (int i = 0; i < 16; i++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0,
                   (i == 0) ? 2'd0 : 2'd2, (4 + i > 15) ? 4'd15 : 4'(4 + i));
            step($sformatf("sat%0d", i), v);
        end

        // Reset asserted mid-stall: control outputs drop at once,
        // registered state/counter clear on the following cycle.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 15);
        v.rst = 1'b1;
        step("rst_mid", v);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("post_rst", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
